// File: rtl/spi_fifo_v2.sv
// ---------------------------------------------------------------------------
// spi_fifo_v2
//   Synchronous FIFO for the SPI slave TX/RX data paths. Single clock domain,
//   registered read (1-cycle latency, qualified by readValid), protected
//   push/pop, occupancy count, programmable almost-full/almost-empty flags
//   and a synchronous flush. Storage is an unreset array so it maps to RAM.
//
//   Optional build macro: SPI_FIFO_ERR_EN
//     adds err_clr (in), overflow/underflow (out) sticky error flags.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear, wins over push/pop
//   writeData, writeEn    push data / request
//   readEn                pop request
//   readData, readValid   popped word (registered) and its 1-cycle strobe
//   full, empty           occupancy == DEPTH / == 0
//   almost_full           count >= AFULL_THRESH
//   almost_empty          count <= AEMPTY_THRESH
//   count                 occupancy 0..DEPTH
//   err_clr, overflow, underflow   (SPI_FIFO_ERR_EN only)
// ---------------------------------------------------------------------------
module spi_fifo_v2 #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         writeData,
    input  logic                     writeEn,
    input  logic                     readEn,
    output logic [WIDTH-1:0]         readData,
    output logic                     readValid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
`ifdef SPI_FIFO_ERR_EN
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // with equal low bits; their modulo difference is the occupancy.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    // Acceptance uses the registered flags only: no write-through when empty,
    // no push into a slot being freed when full.
    assign push_ok = writeEn && !full  && !flush;
    assign pop_ok  = readEn  && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage has no reset so it can be implemented as RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= writeData;
    end

    // readData holds its value across idle cycles and flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= pop_ok;
            if (pop_ok) readData <= mem[rd_ptr[AW-1:0]];
        end
    end

`ifdef SPI_FIFO_ERR_EN
    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (writeEn && full)    overflow  <= 1'b1;
            else if (err_clr)       overflow  <= 1'b0;
            if (readEn && empty)    underflow <= 1'b1;
            else if (err_clr)       underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_fifo_v2.sv
// Directed bench for spi_fifo_v2 (WIDTH=8, DEPTH=16, thresholds 14/2):
// a vector table for short push/pop/flush sequences plus hand-written
// fill/drain, wrap, boundary, flush and async-reset sequences.
module tb_spi_fifo_v2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] writeData = '0;
    logic       writeEn = 1'b0;
    logic       readEn = 1'b0;
    logic [7:0] readData;
    logic       readValid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
`ifdef SPI_FIFO_ERR_EN
    logic       err_clr = 1'b0;
    logic       overflow, underflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spi_fifo_v2 #(.WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .writeData(writeData), .writeEn(writeEn), .readEn(readEn),
        .readData(readData), .readValid(readValid),
        .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SPI_FIFO_ERR_EN
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    typedef struct {
        logic       we, re, fl;
        logic [7:0] wd;
        int         cnt;
        logic       emp, ful, rv, ae, af;
        logic [7:0] rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic fl, input logic [7:0] wd);
        writeEn = we; readEn = re; flush = fl; writeData = wd;
    endtask

    task automatic push(input logic [7:0] wd);
        drive(1'b1, 1'b0, 1'b0, wd);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // {we, re, fl, wd, cnt, emp, ful, rv, ae, af, rd}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h11};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 8'h55, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_rdata", readData, 0);
        chk("rst_rvalid", readValid, 0);

        // Table-driven short sequences
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].fl, vecs[i].wd);
            tick();
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].emp);
            chk($sformatf("v%0d_full", i), full, vecs[i].ful);
            chk($sformatf("v%0d_rvalid", i), readValid, vecs[i].rv);
            chk($sformatf("v%0d_rdata", i), readData, vecs[i].rd);
            chk($sformatf("v%0d_aempty", i), almost_empty, vecs[i].ae);
            chk($sformatf("v%0d_afull", i), almost_full, vecs[i].af);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill 0x00..0x0F; threshold flags follow the count edge by edge
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk($sformatf("fill%0d_count", i), count, i + 1);
            chk($sformatf("fill%0d_afull", i), almost_full, (i + 1 >= 14) ? 1 : 0);
            chk($sformatf("fill%0d_aempty", i), almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        chk("fill_full", full, 1);

        // Push while full is dropped
        push(8'hEE);
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
`ifdef SPI_FIFO_ERR_EN
        chk("ovf_flag", overflow, 1);
        tick();
        chk("ovf_hold", overflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
`endif

        // Drain: data in order, one cycle after readEn, with readValid
        readEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("drain%0d_data", i), readData, i);
            chk($sformatf("drain%0d_rv", i), readValid, 1);
            chk($sformatf("drain%0d_count", i), count, 15 - i);
        end
        readEn = 1'b0;
        chk("drain_empty", empty, 1);

        // Pop while empty: no strobe, data holds
        readEn = 1'b1;
        tick();
        readEn = 1'b0;
        chk("udf_rv", readValid, 0);
        chk("udf_data", readData, 8'h0F);
        chk("udf_count", count, 0);
`ifdef SPI_FIFO_ERR_EN
        chk("udf_flag", underflow, 1);
`endif

        // Wrap: advance pointers by 10, then fill with 0xA0..0xAF
        for (int i = 0; i < 10; i++) push(8'h90 + 8'(i));
        readEn = 1'b1;
        repeat (10) tick();
        readEn = 1'b0;
        chk("wrap_pre_empty", empty, 1);
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        chk("wrap_full", full, 1);
        chk("wrap_msb_diff", int'(dut.wr_ptr[4] ^ dut.rd_ptr[4]), 1);
        readEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("wrap%0d_data", i), readData, 8'hA0 + i);
        end
        readEn = 1'b0;
        chk("wrap_empty", empty, 1);

        // Push+pop at count 5 keeps count
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        drive(1'b1, 1'b1, 1'b0, 8'h77);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("pp5_count", count, 5);
        chk("pp5_data", readData, 8'h50);
        chk("pp5_rv", readValid, 1);

        // Flush at count 7 with a concurrent push
        push(8'h78);
        push(8'h79);
        chk("pre_flush_count", count, 7);
        drive(1'b1, 1'b0, 1'b1, 8'hCC);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_rv", readValid, 0);
        chk("flush_rdata", readData, 8'h50);
        tick();
        chk("flush_stay_empty", empty, 1);

        // Async reset mid-burst takes effect before the next edge
        push(8'h5A);
        push(8'h6B);
        drive(1'b1, 1'b1, 1'b0, 8'h7C);
        tick();
        chk("prerst_rv", readValid, 1);
        chk("prerst_data", readData, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_rv", readValid, 0);
        chk("arst_rdata", readData, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
